// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped 8N1 UART transmitter.
// Bus stores to TXDATA are queued in a small FIFO. The transmit FSM drains the
// FIFO one byte per frame: a start bit, 8 data bits sent LSB first, then a stop
// bit. Each bit lasts BAUDDIV+1 clock cycles.
module bus_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        busWe,
  input  logic [3:0]  busAddr,
  input  logic [2:0]  strb,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t state, next_state;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             enable;
  logic [15:0]      baud_div;
  logic [15:0]      timer;
  logic [7:0]       shift;
  logic [2:0]       bit_cnt;

  logic [1:0]  reg_sel;
  logic        wr_en;
  logic        push_req;
  logic        push_ok;
  logic        overflow_set;
  logic        status_wr;
  logic        full;
  logic        empty;
  logic        bit_done;
  logic        pop;
  logic        shift_en;
  logic [31:0] count_ext;
  logic [3:0]  count_field;
  logic [31:0] status_word;
  logic [31:0] read_word;

  // Access size and the low address bits are deliberately ignored; every access is a word.
  logic unused_inputs;
  assign unused_inputs = ^{strb, busAddr[1:0], busWData[31:16]};

  assign reg_sel   = busAddr[3:2];
  assign wr_en     = sel & busWe;
  assign push_req  = wr_en && (reg_sel == 2'd0);
  assign status_wr = wr_en && (reg_sel == 2'd1);
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign bit_done  = (timer == 16'd0);

  // A push into a full FIFO is still accepted when the FSM pops on the same edge.
  assign push_ok      = push_req && (!full || pop);
  assign overflow_set = push_req && full && !pop;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: decides when to pop the FIFO and when to step to the next data bit.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !empty) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (bit_done) begin
          next_state = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            next_state = STOP;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (enable && !empty) begin
            pop        = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Serial line level follows the FSM state, so it drops back to idle-high as soon as reset is asserted.
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

  // Bit timer, shift register and bit counter; BAUDDIV is sampled only when a new bit starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer   <= '0;
      shift   <= '0;
      bit_cnt <= '0;
    end else if (pop) begin
      shift   <= fifo_mem[rd_ptr];
      bit_cnt <= '0;
      timer   <= baud_div;
    end else if (state != IDLE) begin
      timer <= bit_done ? baud_div : (timer - 16'd1);
      if (shift_en) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // FIFO pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push_ok && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= busWData[7:0];
    end
  end

  // Software-visible control registers; a dropped byte setting overflow beats a same-edge clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      baud_div <= DEFAULT_DIV;
      enable   <= 1'b0;
    end else begin
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (status_wr && busWData[3]) begin
        overflow <= 1'b0;
      end
      if (wr_en && (reg_sel == 2'd2)) begin
        baud_div <= busWData[15:0];
      end
      if (wr_en && (reg_sel == 2'd3)) begin
        enable <= busWData[0];
      end
    end
  end

  assign count_ext   = 32'(count);
  assign count_field = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign status_word = {20'd0, count_field, 4'd0, overflow, empty, full, (state != IDLE)};

  // Combinational read mux; the bus sees zero whenever this block is not selected.
  always_comb begin
    read_word = 32'd0;
    case (reg_sel)
      2'd1:    read_word = status_word;
      2'd2:    read_word = {16'd0, baud_div};
      2'd3:    read_word = {31'd0, enable};
      default: read_word = 32'd0;
    endcase
    busRData = sel ? read_word : 32'd0;
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// tb_bus_uart_tx: directed bench for bus_uart_tx. Expected bytes go into a
// scoreboard queue as they are stored; a serial receiver on tx pops and compares
// them, timing each bit from the bench's own copy of BAUDDIV.
module tb_bus_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        busWe;
  logic [3:0]  busAddr;
  logic [2:0]  strb;
  logic [31:0] busWData;
  logic [31:0] busRData;
  logic        tx;

  bus_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd867)) dut (
    .clk(clk), .reset(reset), .sel(sel), .busWe(busWe), .busAddr(busAddr),
    .strb(strb), .busWData(busWData), .busRData(busRData), .tx(tx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] sb[$];
  int         start_hist[$];
  int         len_hist[$];
  int         frames_done = 0;

  logic [15:0] model_div;
  logic [15:0] div_old;

  // Free-running cycle count used to time-stamp received frames.
  always @(posedge clk) cyc <= cyc + 1;

  // Bench copy of BAUDDIV; div_old is the value in force just before the latest edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_div <= 16'd867;
      div_old   <= 16'd867;
    end else begin
      div_old <= model_div;
      if (sel && busWe && busAddr[3:2] == 2'd2) model_div <= busWData[15:0];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus store, committed on the next rising edge.
  task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
    busAddr  = addr;
    busWData = data;
    strb     = 3'($urandom_range(0, 7));
    sel      = 1'b1;
    busWe    = 1'b1;
    @(posedge clk);
    #1;
    sel   = 1'b0;
    busWe = 1'b0;
  endtask

  task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
    busAddr = addr;
    busWe   = 1'b0;
    sel     = 1'b1;
    #1;
    data = busRData;
    sel  = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] data, input bit accepted);
    applyStimulus(4'h0, {24'd0, data});
    if (accepted) sb.push_back(data);
  endtask

  logic mon_active = 1'b0;

  task automatic waitIdle(input int bound, input string tag);
    logic [31:0] st;
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      waitCycles(1);
      readReg(4'h4, st);
      if (sb.size() == 0 && !mon_active && st[0] == 1'b0) done = 1;
    end
    checkOutput({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  // Serial receiver: samples tx once per cycle, checks every bit is stable for its full length.
  logic       prev_tx = 1'b1;
  int         bit_idx, bit_left, frame_start;
  logic       bit_val, frame_ok, exp_valid;
  logic [7:0] rx_byte, exp_byte;

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (reset !== 1'b1) begin
        mon_active = 1'b0;
        prev_tx    = tx;
      end else begin
        if (!mon_active && prev_tx === 1'b1 && tx === 1'b0) begin
          mon_active  = 1'b1;
          bit_idx     = 0;
          bit_left    = 0;
          frame_ok    = 1'b1;
          frame_start = cyc;
          start_hist.push_back(cyc);
          exp_valid = (sb.size() != 0);
          exp_byte  = exp_valid ? sb.pop_front() : 8'h00;
        end
        if (mon_active) begin
          if (bit_left == 0) begin
            bit_left = int'(div_old) + 1;
            bit_val  = tx;
          end else if (tx !== bit_val) begin
            frame_ok = 1'b0;
          end
          bit_left--;
          if (bit_left == 0) begin
            if (bit_idx == 0 && bit_val !== 1'b0) frame_ok = 1'b0;
            if (bit_idx >= 1 && bit_idx <= 8) rx_byte[bit_idx-1] = bit_val;
            if (bit_idx == 9) begin
              if (bit_val !== 1'b1) frame_ok = 1'b0;
              mon_active = 1'b0;
              frames_done++;
              len_hist.push_back(cyc - frame_start + 1);
              checkOutput("frame_shape", 32'(frame_ok), 32'd1);
              checkOutput("frame_expected", 32'(exp_valid), 32'd1);
              checkOutput("frame_byte", 32'(rx_byte), 32'(exp_byte));
            end
            bit_idx++;
          end
        end
        prev_tx = tx;
      end
    end
  end

  // Hard stop in case a wait never completes.
  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed no completion, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] d;
  logic [15:0] seq;
  int          nseq, last, fb, g1, g2;
  bit          seen;

  initial begin : stimulus
    reset    = 1'b0;
    sel      = 1'b0;
    busWe    = 1'b0;
    busAddr  = 4'h0;
    strb     = 3'd0;
    busWData = 32'd0;

    // Reset values
    waitCycles(3);
    checkOutput("tx_in_reset", 32'(tx), 32'd1);
    readReg(4'h4, d); checkOutput("status_in_reset", d, 32'h4);
    reset = 1'b1;
    waitCycles(1);
    readReg(4'h4, d); checkOutput("status_reset", d, 32'h0000_0004);
    readReg(4'h8, d); checkOutput("bauddiv_reset", d, 32'h0000_0363);
    readReg(4'hC, d); checkOutput("ctrl_reset", d, 32'h0);
    readReg(4'h0, d); checkOutput("txdata_read", d, 32'h0);
    #1 checkOutput("rdata_unselected", busRData, 32'h0);

    // Single byte: BAUDDIV written via an unaligned address with upper bits set
    applyStimulus(4'hB, 32'hABCD_0003);
    readReg(4'h8, d); checkOutput("bauddiv_upper_zero", d, 32'h3);
    applyStimulus(4'hC, 32'h1);
    pushByte(8'hA5, 1);
    checkOutput("tx_before_start", 32'(tx), 32'd1);
    waitCycles(1);
    checkOutput("tx_start_edge", 32'(tx), 32'd0);
    waitCycles(39);
    readReg(4'h4, d); checkOutput("busy_last_cycle", 32'(d[0]), 32'd1);
    waitCycles(1);
    readReg(4'h4, d); checkOutput("busy_cleared", d, 32'h4);
    checkOutput("single_frame_len", 32'(len_hist.size() > 0 ? len_hist[$] : -1), 32'd40);

    // Back-to-back frames
    applyStimulus(4'hC, 32'h0);
    pushByte(8'h00, 1);
    pushByte(8'hFF, 1);
    pushByte(8'h55, 1);
    readReg(4'h4, d); checkOutput("b2b_queued_status", d, 32'h0000_0300);
    start_hist.delete();
    applyStimulus(4'hC, 32'h1);
    seq  = 16'h0;
    nseq = 0;
    last = -1;
    for (int i = 0; i < 140; i++) begin
      readReg(4'h4, d);
      if (int'(d[11:8]) != last) begin
        seq  = {seq[11:0], d[11:8]};
        nseq++;
        last = int'(d[11:8]);
      end
      waitCycles(1);
    end
    checkOutput("b2b_count_steps", {nseq[15:0], seq}, {16'd4, 16'h3210});
    waitIdle(100, "b2b");
    g1 = (start_hist.size() >= 2) ? start_hist[1] - start_hist[0] : -1;
    g2 = (start_hist.size() >= 3) ? start_hist[2] - start_hist[1] : -1;
    checkOutput("b2b_frames", 32'(start_hist.size()), 32'd3);
    checkOutput("b2b_gap1", 32'(g1), 32'd40);
    checkOutput("b2b_gap2", 32'(g2), 32'd40);

    // Overflow: ninth byte dropped
    applyStimulus(4'hC, 32'h0);
    for (int i = 0; i < 9; i++) pushByte(8'h10 + 8'(i), i < 8);
    readReg(4'h4, d); checkOutput("ovf_status", d, 32'h0000_080A);
    applyStimulus(4'h4, 32'h8);
    readReg(4'h4, d); checkOutput("ovf_cleared", d, 32'h0000_0802);
    fb = frames_done;
    applyStimulus(4'hC, 32'h1);
    waitIdle(400, "ovf");
    checkOutput("ovf_frames", 32'(frames_done - fb), 32'd8);

    // Full push on the pop edge
    applyStimulus(4'hC, 32'h0);
    for (int i = 0; i < 8; i++) pushByte(8'h20 + 8'(i), 1);
    readReg(4'h4, d); checkOutput("fpp_full", d, 32'h0000_0802);
    fb = frames_done;
    applyStimulus(4'hC, 32'h1);
    pushByte(8'h28, 1);
    readReg(4'h4, d); checkOutput("fpp_status", d, 32'h0000_0803);
    waitIdle(450, "fpp");
    checkOutput("fpp_frames", 32'(frames_done - fb), 32'd9);

    // BAUDDIV 3 -> 7 during data bit 2
    pushByte(8'h3C, 1);
    waitCycles(13);
    applyStimulus(4'h8, 32'h7);
    waitIdle(200, "midbaud");
    checkOutput("midbaud_len", 32'(len_hist.size() > 0 ? len_hist[$] : -1), 32'd64);
    applyStimulus(4'h8, 32'h3);

    // Clearing enable mid-frame
    applyStimulus(4'hC, 32'h0);
    pushByte(8'h81, 1);
    pushByte(8'h42, 1);
    fb = frames_done;
    applyStimulus(4'hC, 32'h1);
    waitCycles(10);
    applyStimulus(4'hC, 32'h0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (frames_done > fb) seen = 1;
      waitCycles(1);
    end
    waitCycles(20);
    readReg(4'h4, d); checkOutput("en_clear_waiting", d, 32'h0000_0100);
    checkOutput("en_clear_frames", 32'(frames_done - fb), 32'd1);
    applyStimulus(4'hC, 32'h1);
    waitIdle(100, "en_resume");
    checkOutput("en_resume_frames", 32'(frames_done - fb), 32'd2);

    // Reset mid-frame
    pushByte(8'h00, 1);
    waitCycles(8);
    checkOutput("tx_low_before_reset", 32'(tx), 32'd0);
    #2 reset = 1'b0;
    #1 checkOutput("tx_reset_async", 32'(tx), 32'd1);
    sb.delete();
    waitCycles(2);
    reset = 1'b1;
    readReg(4'h4, d); checkOutput("status_after_reset2", d, 32'h0000_0004);
    readReg(4'h8, d); checkOutput("bauddiv_after_reset2", d, 32'h0000_0363);
    fb = frames_done;
    waitCycles(20);
    checkOutput("no_frame_after_reset", 32'(frames_done - fb), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_uart_tx.md
# bus_uart_tx

Memory-mapped UART transmitter that answers CPU data-bus accesses as a bus responder. It sits behind the system address decoder on the same strb/busWe/busAddr/busWData/busRData bus the RV32I core drives, and buffers stored bytes in a FIFO. It serialises them 8N1 on `tx` at a software-programmable bit period.

## Interface
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2
- DEFAULT_DIV, 16'd867, reset value of BAUDDIV; bit period is BAUDDIV+1 clk cycles
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset; one clock domain
- sel  input  1  address-decoder select for this block
- busWe  input  1  write strobe, valid with sel
- busAddr  input  4  byte offset; only [3:2] decoded, [1:0] ignored
- strb  input  3  access-size code from core; ignored, every access treated as a word
- busWData  input  32  write data
- busRData  output  32  read data, combinational; 0 when sel=0
- tx  output  1  serial line, idle high

## Operation
- Register map, by busAddr[3:2]:
  - 0 TXDATA (W): push busWData[7:0]; reads return 0
  - 1 STATUS (R): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[11:8] count (saturating field, count ≤ 15 shown), rest 0; writing 1 to bit3 clears overflow
  - 2 BAUDDIV (RW): bits[15:0]; upper bits read 0
  - 3 CTRL (RW): bit0 enable
- A write commits on every rising edge with sel=1 and busWe=1. The core holds busWe for exactly one cycle per store. Reads have no side effects.
- Push when not full: byte enters FIFO tail, count+1.
- Push when full with no same-cycle pop: byte dropped, overflow set.
- Push when full with same-cycle pop: byte accepted, count unchanged, no overflow.
- FSM states are IDLE, START, DATA, STOP:
  - IDLE: if enable=1 and FIFO not empty, pop the head into an 8-bit shift register, load the bit counter, go to START. Otherwise tx=1.
  - START: tx=0 for one bit period, then DATA.
  - DATA: 8 bit periods, LSB first, tx = shift[0]; shift right at each bit boundary. After bit 7, go to STOP.
  - STOP: tx=1 for one bit period. At the end, if enable=1 and FIFO not empty, pop and go straight to START with no idle cycle. Otherwise go to IDLE.
- Bit timer: 16-bit down counter loaded with BAUDDIV at each bit start. A bit boundary occurs when the counter reaches 0. BAUDDIV=0 gives a 1-cycle bit.
- A BAUDDIV write mid-bit takes effect at the next counter reload. The current bit keeps its length.
- Clearing enable mid-frame: the current frame completes, then the FSM idles. Queued bytes are retained.
- Simultaneous STATUS overflow-clear and overflow-set event on the same edge: set wins.

## Timing
- Reset (asynchronous, while reset=0): tx=1, FSM=IDLE, FIFO empty (count=0, pointers 0), overflow=0, BAUDDIV=DEFAULT_DIV, enable=0. busRData is combinational and reflects these values.
- Reset mid-frame: tx returns to 1 immediately, the frame is aborted, and the FIFO is flushed.
- Write latency: a TXDATA push at edge E is visible in STATUS after E.
- With enable=1 and the FSM in IDLE, the pop and tx falling edge occur at edge E+1.
- One frame lasts exactly 10×(BAUDDIV+1) cycles from the tx falling edge to the end of the stop bit.
- Back-to-back frames have no gap between a stop bit and the next start bit.
- busRData settles in the same cycle as busAddr/sel, with no wait states.

## Test plan
- Reset values:
  - Hold reset=0 mid-frame → tx=1 at once.
  - After release, STATUS=0x0000_0004 and BAUDDIV reads 0x0000_0363.
- Single byte:
  - Stimulus: BAUDDIV=3, enable=1, write 0xA5.
  - Required: tx low one edge later; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop high 4 cycles; busy clears after 40 cycles.
- Back-to-back:
  - Stimulus: with enable=0, push 0x00,0xFF,0x55; then set enable=1.
  - Required: three contiguous frames with no idle cycle; STATUS count steps 3→2→1→0.
- Overflow:
  - Stimulus: enable=0, push 9 bytes.
  - Required: full=1, count=8, overflow=1, and the 9th byte is never transmitted.
  - Stimulus: write STATUS=0x8.
  - Required: overflow=0.
- Full push with pop:
  - Stimulus: fill the FIFO, enable, and push on the exact pop edge.
  - Required: count stays 8, overflow=0, and all 9 bytes are transmitted in order.
- Mid-frame control:
  - Stimulus: change BAUDDIV 3→7 during bit 2.
  - Required: bit 2 lasts 4 cycles and bit 3 onward last 8 cycles.
  - Stimulus: clear enable mid-frame.
  - Required: the frame finishes and the next queued byte waits.
